seg7_bcd_display: RTL and testbench
===================================

// Module: seg7_bcd_display
// PURPOSE
//  - Downstream consumer of the binary-to-BCD stage. Latches a 3-digit BCD value
//    (HUNDREDS/TENS/ONES) on a load strobe and time-multiplexes it onto a 4-digit
//    common-anode seven-segment display.
//  - Sits between the BCD converter output and the board display pins.
//  - Rightmost three digits show ones/tens/hundreds; the leftmost digit is always blank.
// PARAMETERS
//  - REFRESH_DIV  100000  CLK cycles each digit is held (1 kHz/digit at 100 MHz); legal range >=2
//  - CNT_W        17      refresh counter width; 2**CNT_W must be >= REFRESH_DIV
// PORTS
//  - CLK             in   1  system clock; all logic on rising edge
//  - RESET           in   1  synchronous, active-high reset
//  - LOAD            in   1  1-cycle strobe: capture HUNDREDS/TENS/ONES into shadow regs
//  - HUNDREDS        in   4  BCD hundreds digit
//  - TENS            in   4  BCD tens digit
//  - ONES            in   4  BCD ones digit
//  - DISPLAY_EN      in   1  1 = drive anodes; 0 = all digits dark (scan keeps running)
//  - SEG_SELECT_OUT  out  4  active-low anode enables; bit0 = rightmost digit
//  - HEX_OUT         out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1 (off)
// BEHAVIOUR
//  - Reset values (RESET sampled high at a CLK edge):
//    - refresh_cnt=0, digit_idx=0, shadow regs=0
//    - SEG_SELECT_OUT=4'b1111, HEX_OUT=8'hFF
//    - LOAD is ignored while RESET is high; reset mid-scan aborts at the next edge.
//  - Shadow capture: on an edge with LOAD=1, shadow_{h,t,o} <= inputs. Inputs are
//    ignored otherwise.
//  - Refresh counter: counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and
//    digit_idx advances 0->1->2->3->0. These are the only scan states; 3 wraps to 0.
//  - Output register: SEG_SELECT_OUT/HEX_OUT are registered from the current
//    digit_idx and shadow regs, giving 1 cycle latency after an idx or shadow change.
//    - A LOAD coincident with a digit advance shows the new value on the new digit
//      one edge later. No tearing within a digit slot beyond that.
//  - Digit map:
//    - idx0 -> ones, anode 4'b1110
//    - idx1 -> tens, 4'b1101
//    - idx2 -> hundreds, 4'b1011
//    - idx3 -> blank (HEX_OUT=8'hFF), 4'b0111
//  - Anodes: when DISPLAY_EN=0 the registered anode value is 4'b1111. HEX_OUT still
//    updates. The counter and idx are unaffected.
//  - Glyphs (HEX_OUT, dp off):
//    - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//    - Non-BCD codes 10..15 show as hex glyphs: A=88 b=83 C=C6 d=A1 E=86 F=8E
//  - A blanked digit outputs HEX_OUT=8'hFF with its anode still asserted.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined:
//    - hundreds digit blanked when shadow_h==0
//    - tens digit blanked when shadow_h==0 && shadow_t==0
//    - ones digit never blanked (value 0 shows "0")
//  - LEADING_ZERO_BLANK_EN undefined: all three digits always show their glyph,
//    e.g. 7 displays "007".
// TESTING (bench uses REFRESH_DIV=4)
//  - Reset: hold RESET 2 cycles -> SEG_SELECT_OUT=1111, HEX_OUT=FF. After release,
//    the first registered output is anode 1110, HEX_OUT=C0.
//  - Scan: LOAD H=1,T=2,O=3 -> anodes cycle 1110/1101/1011/0111, each held 4 cycles,
//    with HEX_OUT B0/A4/F9/FF; the sequence repeats after 16 cycles.
//  - Load timing: LOAD O=9 during the idx0 slot -> HEX_OUT changes C0->90 exactly
//    1 cycle after the LOAD edge. Inputs changed without LOAD -> no output change.
//  - Enable: DISPLAY_EN=0 -> anodes 1111 from the next edge. Re-enable in the
//    idx2 slot -> anode 1011 shows with no phase slip.
//  - Blanking: load 0,0,7 -> with LEADING_ZERO_BLANK_EN HEX_OUT FF/FF/F8; without
//    it C0/C0/F8. Loading 0,0,0 with the macro shows the ones digit as C0.
//  - Edge/non-BCD: load H=4'hF,T=4'hA,O=0 -> 8E/88/C0. RESET asserted mid-slot ->
//    outputs FF/1111 next edge, and shadow regs are 0 after release.

Source files
------------

// File: rtl/seg7_bcd_display_if.sv
// Purpose : groups the BCD load path, display enable and seven-segment pins.
// Latency : none, wiring only.
// Backpressure: none; LOAD is a one-cycle strobe with no ready.
//
// Signals:
//   LOAD            1-cycle strobe, capture HUNDREDS/TENS/ONES
//   HUNDREDS/TENS/ONES  4-bit BCD digits (10..15 show as hex glyphs)
//   DISPLAY_EN      1 = drive anodes, 0 = all digits dark
//   SEG_SELECT_OUT  active-low anode enables, bit0 = rightmost digit
//   HEX_OUT         active-low segments {dp,g,f,e,d,c,b,a}
// master = BCD source / board side, slave = the display driver.
interface seg7_bcd_display_if;
  logic       LOAD;
  logic [3:0] HUNDREDS;
  logic [3:0] TENS;
  logic [3:0] ONES;
  logic       DISPLAY_EN;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;

  modport master (
    output LOAD,
    output HUNDREDS,
    output TENS,
    output ONES,
    output DISPLAY_EN,
    input  SEG_SELECT_OUT,
    input  HEX_OUT
  );

  modport slave (
    input  LOAD,
    input  HUNDREDS,
    input  TENS,
    input  ONES,
    input  DISPLAY_EN,
    output SEG_SELECT_OUT,
    output HEX_OUT
  );
endinterface

// File: rtl/seg7_bcd_display.sv
// Purpose : latch a 3-digit BCD value and scan it onto a 4-digit common-anode display.
// Latency : 1 cycle from a digit-index or shadow-register change to the output pins.
// Backpressure: none; LOAD is always accepted (except during RESET).
//
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-high
//   disp   seg7_bcd_display_if.slave (LOAD, HUNDREDS, TENS, ONES, DISPLAY_EN,
//          SEG_SELECT_OUT, HEX_OUT)
// Parameters:
//   REFRESH_DIV  cycles each digit is held (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, blank a leading-zero hundreds digit and
//                          a leading-zero tens digit; the ones digit is never blanked.
module seg7_bcd_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                 CLK,
  input  logic                 RESET,
  seg7_bcd_display_if.slave    disp
);

  // Scan positions; the leftmost digit (DIG_BLANK) is always dark.
  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_BLANK    = 2'd3
  } digit_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] refresh_cnt;
  logic             slot_end;
  digit_e           digit_idx;
  digit_e           digit_idx_nxt;

  logic [3:0] shadow_h;
  logic [3:0] shadow_t;
  logic [3:0] shadow_o;

  logic       blank_h;
  logic       blank_t;

  logic [3:0] anode_nxt;
  logic [7:0] hex_nxt;
  logic [3:0] anode_q;
  logic [7:0] hex_q;

  // Segment patterns, active low, dp bit kept high (off).
  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Refresh counter: one digit slot lasts REFRESH_DIV cycles.
  // ---------------------------------------------------------------------------
  assign slot_end = (refresh_cnt == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt <= '0;
    end else if (slot_end) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan state machine.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      digit_idx <= DIG_ONES;
    end else begin
      digit_idx <= digit_idx_nxt;
    end
  end

  always_comb begin
    digit_idx_nxt = digit_idx;
    if (slot_end) begin
      case (digit_idx)
        DIG_ONES:     digit_idx_nxt = DIG_TENS;
        DIG_TENS:     digit_idx_nxt = DIG_HUNDREDS;
        DIG_HUNDREDS: digit_idx_nxt = DIG_BLANK;
        default:      digit_idx_nxt = DIG_ONES;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: the value shown only changes on a LOAD strobe, so the
  // upstream converter is free to churn its outputs between loads.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_h <= 4'd0;
      shadow_t <= 4'd0;
      shadow_o <= 4'd0;
    end else if (disp.LOAD) begin
      shadow_h <= disp.HUNDREDS;
      shadow_t <= disp.TENS;
      shadow_o <= disp.ONES;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression. Tens is only a leading zero when hundreds is too.
  // ---------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_h = (shadow_h == 4'd0);
  assign blank_t = (shadow_h == 4'd0) && (shadow_t == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output decode. DISPLAY_EN only gates the anodes; segments keep tracking the
  // scan so re-enabling resumes in phase with no glitch on the segment lines.
  // ---------------------------------------------------------------------------
  always_comb begin
    anode_nxt = 4'b1111;
    hex_nxt   = 8'hFF;
    case (digit_idx)
      DIG_ONES: begin
        anode_nxt = 4'b1110;
        hex_nxt   = glyph(shadow_o);
      end
      DIG_TENS: begin
        anode_nxt = 4'b1101;
        hex_nxt   = blank_t ? 8'hFF : glyph(shadow_t);
      end
      DIG_HUNDREDS: begin
        anode_nxt = 4'b1011;
        hex_nxt   = blank_h ? 8'hFF : glyph(shadow_h);
      end
      default: begin
        anode_nxt = 4'b0111;
        hex_nxt   = 8'hFF;
      end
    endcase
    if (!disp.DISPLAY_EN) begin
      anode_nxt = 4'b1111;
    end
  end

  // Registered pins: clean edges to the board, one cycle behind the scan state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      anode_q <= 4'b1111;
      hex_q   <= 8'hFF;
    end else begin
      anode_q <= anode_nxt;
      hex_q   <= hex_nxt;
    end
  end

  assign disp.SEG_SELECT_OUT = anode_q;
  assign disp.HEX_OUT        = hex_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Bench for seg7_bcd_display with REFRESH_DIV=4: directed scenarios followed by
// randomized LOAD / digit / enable / reset traffic, every cycle compared with a
// reference model derived from edge counts and the digit/glyph tables.
module tb_seg7_bcd_display;

  localparam int DIV = 4;

  logic CLK;
  logic RESET;

  seg7_bcd_display_if dif ();

  seg7_bcd_display #(
    .REFRESH_DIV (DIV),
    .CNT_W       (3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .disp  (dif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: edges since reset released, and the captured digits.
  int         n_edges = 0;
  logic [3:0] m_h = 4'd0;
  logic [3:0] m_t = 4'd0;
  logic [3:0] m_o = 4'd0;

  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Apply the current inputs at one clock edge, advance the model, check outputs.
  task automatic tick();
    logic [3:0] exp_an;
    logic [7:0] exp_hex;
    int         pos;
    @(posedge CLK);
    if (RESET) begin
      exp_an  = 4'b1111;
      exp_hex = 8'hFF;
      n_edges = 0;
      m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
    end else begin
      // Output reflects the scan position and digits held before this edge.
      pos = (n_edges / DIV) % 4;
      case (pos)
        0: exp_hex = glyph_tbl[m_o];
        1: exp_hex = glyph_tbl[m_t];
        2: exp_hex = glyph_tbl[m_h];
        default: exp_hex = 8'hFF;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (pos == 2 && m_h == 4'd0) exp_hex = 8'hFF;
      if (pos == 1 && m_h == 4'd0 && m_t == 4'd0) exp_hex = 8'hFF;
`endif
      exp_an = dif.DISPLAY_EN ? ~(4'b0001 << pos) : 4'b1111;
      n_edges++;
      if (dif.LOAD) begin
        m_h = dif.HUNDREDS; m_t = dif.TENS; m_o = dif.ONES;
      end
    end
    #1;
    chk("anode", {4'h0, dif.SEG_SELECT_OUT}, {4'h0, exp_an});
    chk("hex", dif.HEX_OUT, exp_hex);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    dif.HUNDREDS = h; dif.TENS = t; dif.ONES = o;
    dif.LOAD = 1'b1;
    tick();
    dif.LOAD = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    dif.LOAD = 1'b0;
    dif.HUNDREDS = 4'd0; dif.TENS = 4'd0; dif.ONES = 4'd0;
    dif.DISPLAY_EN = 1'b1;

    // Reset held two cycles, then free-run with shadows at zero.
    run(2);
    RESET = 1'b0;
    run(5);

    // Scan of 1,2,3 over two full 16-cycle frames.
    load(4'd1, 4'd2, 4'd3);
    run(32);

    // Realign to the ones slot, then load O=9 inside it.
    RESET = 1'b1; run(1); RESET = 1'b0;
    run(1);
    load(4'd0, 4'd0, 4'd9);
    run(6);

    // Inputs wiggle without LOAD: display must not change.
    dif.HUNDREDS = 4'd5; dif.TENS = 4'd6; dif.ONES = 4'd7;
    run(16);

    // Disable, then re-enable partway through the scan.
    dif.DISPLAY_EN = 1'b0; run(9);
    dif.DISPLAY_EN = 1'b1; run(12);

    // Leading zeros, all zeros, non-BCD codes.
    load(4'd0, 4'd0, 4'd7); run(16);
    load(4'd0, 4'd0, 4'd0); run(16);
    load(4'd0, 4'd5, 4'd0); run(16);
    load(4'hF, 4'hA, 4'd0); run(16);

    // Reset mid-slot, with a LOAD that must be ignored.
    run(2);
    RESET = 1'b1;
    dif.LOAD = 1'b1; dif.HUNDREDS = 4'd8; dif.TENS = 4'd8; dif.ONES = 4'd8;
    tick();
    dif.LOAD = 1'b0;
    RESET = 1'b0;
    run(16);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      dif.LOAD       = ($urandom_range(0, 7) == 0);
      dif.HUNDREDS   = 4'($urandom_range(0, 15));
      dif.TENS       = 4'($urandom_range(0, 15));
      dif.ONES       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) dif.HUNDREDS = 4'd0;
      if ($urandom_range(0, 3) == 0) dif.TENS = 4'd0;
      if ($urandom_range(0, 31) == 0) dif.DISPLAY_EN = ~dif.DISPLAY_EN;
      RESET          = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
